bp_pht_ctrl: RTL and testbench
==============================

Name: bp_pht_ctrl

Overview:
Write-side controller and read-side corrector for the pattern history table RAM of the branch predictor.
- After reset, sweeps every PHT entry to a known counter state, because the RAM has no reset.
- Queues branch-resolution updates from the pipeline and computes the 2-bit saturating next state.
- Drives the PHT write bus one write per cycle.
- Patches lookup read data for same-address write hazards.

Parameters:
PHT_ADDR_W, 10, PHT index width; table holds 2^PHT_ADDR_W entries
FIFO_DEPTH, 4, update queue depth; power of 2, at least 2
INIT_STATE, 2'b01, counter value written by the init sweep (weakly not-taken)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
upd_valid_i  in  1  update request from branch resolution
upd_ready_o  out  1  update accepted this cycle when valid&&ready
upd_idx_i  in  PHT_ADDR_W  PHT index of the resolved branch
upd_old_i  in  2  counter state read at prediction time
upd_taken_i  in  1  actual branch direction
pht_wbus_o  out  1+PHT_ADDR_W+2  {we, waddr, wdata} to PHT write port
lk_addr_i  in  PHT_ADDR_W  lookup index from fetch
pht_raddr_o  out  PHT_ADDR_W  lookup index to PHT read port (combinational copy of lk_addr_i)
pht_rdata_i  in  2  PHT read data, 1-cycle latency
lk_state_o  out  2  corrected lookup state, aligned with pht_rdata_i
init_done_o  out  1  high once the sweep is complete

Behaviour:
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Next state: taken gives min(old+1, 3); not-taken gives max(old-1, 0). Use 2-bit arithmetic; no wrap is allowed.
- FSM states are INIT and RUN. Reset (reset==0) selects INIT, clears the sweep counter and flushes the FIFO.
- INIT:
  - Each cycle writes INIT_STATE to address sweep_cnt, then increments sweep_cnt.
  - The write at address 2^PHT_ADDR_W-1 moves the FSM to RUN on the next cycle.
  - The sweep takes exactly 2^PHT_ADDR_W cycles.
  - init_done_o=0 throughout.
- RUN:
  - init_done_o=1.
  - If the FIFO is not empty, pop the head and write {1, idx, next_state} this cycle.
  - Otherwise we=0.
- Updates are enqueued in INIT and in RUN.
  - Next state is computed at enqueue; the FIFO stores {idx, next_state}.
  - upd_ready_o = !full, registered-free.
  - A push while full is not accepted, even if a pop occurs the same cycle; there is no pass-through.
- Push and pop in the same cycle with the FIFO non-empty and non-full: occupancy is unchanged.
- Push into an empty FIFO in RUN: the entry is written the following cycle. Minimum latency is 1 cycle from acceptance to we.
- Bypass:
  - Register lk_addr_i together with the current write {we, waddr, wdata}.
  - Next cycle, if we_q && waddr_q==lk_addr_q, then lk_state_o = wdata_q; otherwise lk_state_o = pht_rdata_i.
  - While init_done_o==0, lk_state_o = INIT_STATE.
- Reset outputs:
  - pht_wbus_o we=0 in the reset cycle; the sweep begins the first cycle after reset deasserts.
  - upd_ready_o=0 during reset; after reset it is 1 (FIFO empty).
  - lk_state_o=INIT_STATE.
  - init_done_o=0.
- Reset mid-sweep or mid-drain: queued updates are discarded and the sweep restarts at index 0.

Optional Feature:
BP_PHT_SKIP_SAT_EN
- Defined: an accepted update whose next_state equals upd_old_i (saturated) is handshaken (ready honoured) but not enqueued, saving RAM writes and FIFO slots.
- Undefined: every accepted update is enqueued and written.

Decomposition:
- The shared package/header (alongside the existing predictor defines) holds:
  - counter state constants SNT/WNT/WT/ST;
  - PHT write-bus width macro and field layout;
  - the saturating next-state function.
- Natural sub-module: bp_pht_upd_fifo. It is a synchronous FIFO with push/pop, full/empty, and depth FIFO_DEPTH.

Test Plan:
- Release reset with PHT_ADDR_W=4 -> writes to addresses 0..15 of 01 on 16 consecutive cycles; init_done_o rises on cycle 17; lk_state_o=01 during the sweep.
- RUN, update idx=5 old=11 taken=1 -> write idx 5 data 11 one cycle later (with BP_PHT_SKIP_SAT_EN: no write, ready still 1).
- RUN, update idx=3 old=00 taken=0 then old=01 taken=1 -> writes 00 then 10.
- During INIT, push 5 updates with FIFO_DEPTH=4 -> 4 accepted, upd_ready_o=0 on the 5th; all 4 written in order on the first 4 RUN cycles; the 5th is accepted when the first pop frees a slot.
- Lookup addr 7 in the same cycle as a write of 10 to addr 7, with pht_rdata_i=01 -> lk_state_o=10 next cycle; lookup addr 8 -> pht_rdata_i passthrough.
- Assert reset with 3 queued entries in RUN -> no further update writes; sweep restarts at 0; FIFO empty.

Source files
------------

// File: rtl/bp_pht_ctrl_pkg.sv
// bp_pht_ctrl_pkg: shared definitions for the PHT write-side controller.
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - write-bus width macro and field layout
//   - controller FSM state type
//   - saturating next-state helper
// Write bus layout, MSB first: {we, waddr[PHT_ADDR_W-1:0], wdata[1:0]}.
`ifndef BP_PHT_WBUS_W
`define BP_PHT_WBUS_W(aw) ((aw) + 3)
`endif

package bp_pht_ctrl_pkg;

    localparam logic [1:0] SNT = 2'b00;  // strongly not-taken
    localparam logic [1:0] WNT = 2'b01;  // weakly not-taken
    localparam logic [1:0] WT  = 2'b10;  // weakly taken
    localparam logic [1:0] ST  = 2'b11;  // strongly taken

    // Field positions inside the write bus (we sits at aw+2).
    localparam int WBUS_DATA_LSB = 0;
    localparam int WBUS_ADDR_LSB = 2;

    typedef enum logic {
        PHT_INIT = 1'b0,
        PHT_RUN  = 1'b1
    } pht_state_e;

    // Saturating update: clamp at ST on taken, at SNT on not-taken.
    function automatic logic [1:0] pht_next_state(input logic [1:0] old, input logic taken);
        logic [1:0] nxt;
        if (taken)
            nxt = (old == ST) ? ST : old + 2'd1;
        else
            nxt = (old == SNT) ? SNT : old - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/bp_pht_ctrl_upd_fifo.sv
// bp_pht_upd_fifo: synchronous FIFO for pending PHT updates.
// Ports:
//   clk, reset    clock, synchronous active-low reset (flushes pointers)
//   push, din     write request / data; ignored while full
//   pop, dout     read request / head data; ignored while empty
//   full, empty   occupancy flags
// Storage is not reset; only the pointers are, which is enough to flush.
module bp_pht_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PTR_W:0]          wr_ptr;
    logic [PTR_W:0]          rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    // Full blocks the push even if a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/bp_pht_ctrl.sv
// bp_pht_ctrl: write-side controller and read-side corrector for the PHT RAM.
//   - After reset, sweeps every entry to INIT_STATE (the RAM has no reset).
//   - Queues branch-resolution updates, computing the saturating next state
//     at enqueue, and drains one write per cycle once the sweep is done.
//   - Patches lookup read data when the looked-up entry was written in the
//     same cycle the address was presented.
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   upd_valid_i/upd_ready_o     update handshake
//   upd_idx_i/old_i/taken_i     resolved branch index, old counter, direction
//   pht_wbus_o                  {we, waddr, wdata} to the PHT write port
//   lk_addr_i/pht_raddr_o       lookup index, forwarded to the PHT read port
//   pht_rdata_i                 PHT read data (1-cycle latency)
//   lk_state_o                  corrected lookup state, aligned with rdata
//   init_done_o                 high once the sweep is complete
// Optional build macro: BP_PHT_SKIP_SAT_EN -- accepted updates that would not
// change the counter (already saturated) are handshaken but not enqueued.
module bp_pht_ctrl
    import bp_pht_ctrl_pkg::*;
#(
    parameter int         PHT_ADDR_W = 10,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   upd_valid_i,
    output logic                                   upd_ready_o,
    input  logic [PHT_ADDR_W-1:0]                  upd_idx_i,
    input  logic [1:0]                             upd_old_i,
    input  logic                                   upd_taken_i,
    output logic [`BP_PHT_WBUS_W(PHT_ADDR_W)-1:0]  pht_wbus_o,
    input  logic [PHT_ADDR_W-1:0]                  lk_addr_i,
    output logic [PHT_ADDR_W-1:0]                  pht_raddr_o,
    input  logic [1:0]                             pht_rdata_i,
    output logic [1:0]                             lk_state_o,
    output logic                                   init_done_o
);

    localparam int ENT_W = PHT_ADDR_W + 2;  // FIFO entry {idx, next_state}

    pht_state_e              state;
    logic [PHT_ADDR_W-1:0]   sweep_cnt;
    logic                    init_done_q;

    logic [1:0]              upd_next;
    logic                    upd_skip;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic [ENT_W-1:0]        fifo_din;
    logic [ENT_W-1:0]        fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;

    logic                    wr_we;
    logic [PHT_ADDR_W-1:0]   wr_addr;
    logic [1:0]              wr_data;

    // Bypass stage: vld_pipe[0] is this cycle's write enable, vld_pipe[1]
    // the registered copy that lines up with pht_rdata_i.
    logic [1:0]              vld_pipe;
    logic [PHT_ADDR_W-1:0]   lk_addr_q;
    logic [PHT_ADDR_W-1:0]   waddr_q;
    logic [1:0]              wdata_q;

    // ---------------- update enqueue ----------------
    assign upd_next    = pht_next_state(upd_old_i, upd_taken_i);
    // Combinational ready; forced low while reset is held.
    assign upd_ready_o = reset && !fifo_full;

`ifdef BP_PHT_SKIP_SAT_EN
    assign upd_skip = (upd_next == upd_old_i);
`else
    assign upd_skip = 1'b0;
`endif

    assign fifo_push = upd_valid_i && upd_ready_o && !upd_skip;
    assign fifo_din  = {upd_idx_i, upd_next};

    bp_pht_upd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------- write bus ----------------
    // Sweep owns the port in INIT; queued updates only drain in RUN.
    always_comb begin
        wr_we    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        fifo_pop = 1'b0;
        if (reset) begin
            if (state == PHT_INIT) begin
                wr_we   = 1'b1;
                wr_addr = sweep_cnt;
                wr_data = INIT_STATE;
            end else if (!fifo_empty) begin
                wr_we    = 1'b1;
                wr_addr  = fifo_dout[ENT_W-1:WBUS_ADDR_LSB];
                wr_data  = fifo_dout[WBUS_ADDR_LSB-1:WBUS_DATA_LSB];
                fifo_pop = 1'b1;
            end
        end
    end

    assign pht_wbus_o = {wr_we, wr_addr, wr_data};

    // ---------------- INIT/RUN FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= PHT_INIT;
            sweep_cnt   <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                PHT_INIT: begin
                    sweep_cnt <= sweep_cnt + PHT_ADDR_W'(1);
                    if (sweep_cnt == '1) begin
                        state       <= PHT_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                PHT_RUN: begin
                    state       <= PHT_RUN;
                    init_done_q <= 1'b1;
                end
                default: begin
                    state       <= PHT_INIT;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign init_done_o = reset && init_done_q;

    // ---------------- lookup bypass ----------------
    assign pht_raddr_o = lk_addr_i;
    assign vld_pipe[0] = wr_we;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_pipe[1] <= 1'b0;
            lk_addr_q   <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            lk_addr_q   <= lk_addr_i;
            waddr_q     <= wr_addr;
            wdata_q     <= wr_data;
        end
    end

    // The RAM returns pre-write data for a same-cycle write, so forward it.
    always_comb begin
        lk_state_o = pht_rdata_i;
        if (!init_done_o)
            lk_state_o = INIT_STATE;
        else if (vld_pipe[1] && (waddr_q == lk_addr_q))
            lk_state_o = wdata_q;
    end

endmodule

// File: tb/tb_bp_pht_ctrl.sv
// tb_bp_pht_ctrl: directed self-checking bench for bp_pht_ctrl with
// PHT_ADDR_W=4, FIFO_DEPTH=4, INIT_STATE=01. Inputs change 1ns after the
// rising edge, outputs are checked 2ns after it.
module tb_bp_pht_ctrl;

    localparam int AW = 4;

    logic          clk;
    logic          reset;
    logic          upd_valid;
    logic          upd_ready;
    logic [AW-1:0] upd_idx;
    logic [1:0]    upd_old;
    logic          upd_taken;
    logic [AW+2:0] pht_wbus;
    logic [AW-1:0] lk_addr;
    logic [AW-1:0] pht_raddr;
    logic [1:0]    pht_rdata;
    logic [1:0]    lk_state;
    logic          init_done;

    int total = 0;
    int bad   = 0;

    bp_pht_ctrl #(
        .PHT_ADDR_W (AW),
        .FIFO_DEPTH (4),
        .INIT_STATE (2'b01)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .upd_valid_i (upd_valid),
        .upd_ready_o (upd_ready),
        .upd_idx_i   (upd_idx),
        .upd_old_i   (upd_old),
        .upd_taken_i (upd_taken),
        .pht_wbus_o  (pht_wbus),
        .lk_addr_i   (lk_addr),
        .pht_raddr_o (pht_raddr),
        .pht_rdata_i (pht_rdata),
        .lk_state_o  (lk_state),
        .init_done_o (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected write bus with we=1.
    function automatic logic [31:0] wb(input logic [AW-1:0] a, input logic [1:0] d);
        return {25'd0, 1'b1, a, d};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] idx, input logic [1:0] old, input logic t);
        upd_valid = v;
        upd_idx   = idx;
        upd_old   = old;
        upd_taken = t;
    endtask

    // Five INIT-phase updates and their expected next states.
    logic [AW-1:0] q_idx [5];
    logic [1:0]    q_old [5];
    logic          q_tk  [5];
    logic [1:0]    q_nxt [5];

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        q_idx[0] = 4'd1; q_old[0] = 2'b00; q_tk[0] = 1'b1; q_nxt[0] = 2'b01;
        q_idx[1] = 4'd2; q_old[1] = 2'b11; q_tk[1] = 1'b0; q_nxt[1] = 2'b10;
        q_idx[2] = 4'd3; q_old[2] = 2'b10; q_tk[2] = 1'b1; q_nxt[2] = 2'b11;
        q_idx[3] = 4'd4; q_old[3] = 2'b01; q_tk[3] = 1'b0; q_nxt[3] = 2'b00;
        q_idx[4] = 4'd9; q_old[4] = 2'b01; q_tk[4] = 1'b1; q_nxt[4] = 2'b10;

        reset     = 1'b0;
        drive(1'b0, '0, 2'b00, 1'b0);
        lk_addr   = '0;
        pht_rdata = 2'b00;

        // Reset state.
        repeat (3) cyc();
        #1;
        chk("rst_we",    32'(pht_wbus[AW+2]), 32'd0);
        chk("rst_ready", 32'(upd_ready), 32'd0);
        chk("rst_done",  32'(init_done), 32'd0);
        chk("rst_lk",    32'(lk_state), 32'd1);

        // Sweep of 16 entries, with 5 updates offered during it.
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (i == 0) reset = 1'b1;
            if (i < 5) drive(1'b1, q_idx[i], q_old[i], q_tk[i]);
            #1;
            chk($sformatf("sweep_wbus%0d", i), 32'(pht_wbus), wb(AW'(i), 2'b01));
            chk($sformatf("sweep_done%0d", i), 32'(init_done), 32'd0);
            chk($sformatf("sweep_lk%0d", i), 32'(lk_state), 32'd1);
            chk($sformatf("sweep_ready%0d", i), 32'(upd_ready), (i < 4) ? 32'd1 : 32'd0);
        end

        // First RUN cycle: head drains, 5th update still blocked.
        cyc(); #1;
        chk("run1_done",  32'(init_done), 32'd1);
        chk("run1_wbus",  32'(pht_wbus), wb(q_idx[0], q_nxt[0]));
        chk("run1_ready", 32'(upd_ready), 32'd0);
        cyc(); #1;
        chk("run2_wbus",  32'(pht_wbus), wb(q_idx[1], q_nxt[1]));
        chk("run2_ready", 32'(upd_ready), 32'd1);
        cyc(); drive(1'b0, '0, 2'b00, 1'b0); #1;
        chk("run3_wbus", 32'(pht_wbus), wb(q_idx[2], q_nxt[2]));
        cyc(); #1;
        chk("run4_wbus", 32'(pht_wbus), wb(q_idx[3], q_nxt[3]));
        cyc(); #1;
        chk("run5_wbus", 32'(pht_wbus), wb(q_idx[4], q_nxt[4]));
        cyc(); #1;
        chk("run6_we", 32'(pht_wbus[AW+2]), 32'd0);

        // Saturated update: idx 5, old 11, taken.
        cyc(); drive(1'b1, 4'd5, 2'b11, 1'b1); #1;
        chk("sat_ready", 32'(upd_ready), 32'd1);
        cyc(); drive(1'b0, '0, 2'b00, 1'b0); #1;
`ifdef BP_PHT_SKIP_SAT_EN
        chk("sat_we", 32'(pht_wbus[AW+2]), 32'd0);
`else
        chk("sat_wbus", 32'(pht_wbus), wb(4'd5, 2'b11));
`endif
        cyc(); #1;
        chk("sat_idle", 32'(pht_wbus[AW+2]), 32'd0);

        // Back-to-back updates to idx 3: 00/NT -> 00, 01/T -> 10.
        cyc(); drive(1'b1, 4'd3, 2'b00, 1'b0); #1;
        cyc(); drive(1'b1, 4'd3, 2'b01, 1'b1); #1;
        chk("b2b_w0", 32'(pht_wbus), wb(4'd3, 2'b00));
        cyc(); drive(1'b0, '0, 2'b00, 1'b0); #1;
        chk("b2b_w1", 32'(pht_wbus), wb(4'd3, 2'b10));
        cyc(); #1;
        chk("b2b_idle", 32'(pht_wbus[AW+2]), 32'd0);

        // Bypass: lookup 7 in the same cycle as a write of 10 to 7.
        cyc(); drive(1'b1, 4'd7, 2'b01, 1'b1); #1;
        cyc(); drive(1'b0, '0, 2'b00, 1'b0); lk_addr = 4'd7; #1;
        chk("byp_wbus",  32'(pht_wbus), wb(4'd7, 2'b10));
        chk("byp_raddr", 32'(pht_raddr), 32'd7);
        cyc(); lk_addr = 4'd8; pht_rdata = 2'b01; #1;
        chk("byp_hit", 32'(lk_state), 32'd2);
        chk("byp_raddr8", 32'(pht_raddr), 32'd8);
        cyc(); pht_rdata = 2'b11; #1;
        chk("byp_pass", 32'(lk_state), 32'd3);

        // Reset from RUN.
        cyc(); reset = 1'b0; #1;
        chk("rst2_we",    32'(pht_wbus[AW+2]), 32'd0);
        chk("rst2_ready", 32'(upd_ready), 32'd0);
        chk("rst2_done",  32'(init_done), 32'd0);
        chk("rst2_lk",    32'(lk_state), 32'd1);
        cyc();

        // Partial sweep with 3 queued updates, then reset mid-sweep.
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 0) reset = 1'b1;
            if (i < 3) drive(1'b1, AW'(10 + i), 2'b01, 1'b1);
            else       drive(1'b0, '0, 2'b00, 1'b0);
            #1;
            chk($sformatf("part_wbus%0d", i), 32'(pht_wbus), wb(AW'(i), 2'b01));
        end
        cyc(); reset = 1'b0; #1;
        chk("rst3_we", 32'(pht_wbus[AW+2]), 32'd0);
        cyc();

        // Sweep restarts at 0; queued entries are gone.
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (i == 0) reset = 1'b1;
            #1;
            chk($sformatf("resweep_wbus%0d", i), 32'(pht_wbus), wb(AW'(i), 2'b01));
        end
        cyc(); #1;
        chk("flush_done",  32'(init_done), 32'd1);
        chk("flush_we",    32'(pht_wbus[AW+2]), 32'd0);
        chk("flush_ready", 32'(upd_ready), 32'd1);
        cyc(); #1;
        chk("flush_we2", 32'(pht_wbus[AW+2]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
